// File: rtl/pattern_sequencer_pkg.sv
// pattern_pkg: shared state encoding and constants for pattern_sequencer and its dwell timer.
package pattern_pkg;

    typedef enum logic [1:0] {
        SHOW     = 2'd0,
        FADE_OUT = 2'd1,
        SWAP     = 2'd2,
        FADE_IN  = 2'd3
    } seq_state_t;

    localparam int         STEP_W      = 3;
    localparam logic [2:0] SPEED_RESET = 3'd4;
    localparam logic [1:0] DIM_MAX     = 2'd3;

    // Saturating 3-bit speed update; simultaneous up and down cancel.
    function automatic logic [STEP_W-1:0] next_speed(input logic [STEP_W-1:0] s, input logic up, input logic dn);
        return (up && !dn && s != 3'd7) ? s + 3'd1 :
               (dn && !up && s != 3'd0) ? s - 3'd1 : s;
    endfunction

endpackage

// File: rtl/frame_dwell_timer.sv
// frame_dwell_timer: counts enabled frame ticks and pulses expire on the DWELL_FRAMES-th one.
module frame_dwell_timer #(
    parameter int DWELL_FRAMES = 600
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic enable,
    input  logic clear,
    output logic expire
);
    localparam int W = $clog2(DWELL_FRAMES);

    logic [W-1:0] r_count;
    logic         w_hit;

    assign w_hit  = r_count == W'(DWELL_FRAMES - 1);
    assign expire = tick && enable && w_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_count <= '0;
        else if (clear)
            r_count <= '0;
        else if (tick && enable)
            r_count <= w_hit ? '0 : r_count + W'(1);
    end

endmodule

// File: rtl/pattern_sequencer.sv
// pattern_sequencer: pattern select, per-frame advance/step size and fade-out/swap/fade-in on change.
// Define AUTO_CYCLE_EN to add dwell-based automatic pattern advance.
module pattern_sequencer
    import pattern_pkg::*;
#(
    parameter int NUM_PATTERNS = 4,
    parameter int DWELL_FRAMES = 600
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_tick,
    input  logic              btn_next,
    input  logic              speed_up,
    input  logic              speed_down,
    input  logic              pause,
    output logic              next_frame,
    output logic [STEP_W-1:0] step_size,
    output logic [2:0]        pattern_sel,
    output logic [1:0]        dim,
    output logic              busy
);
    localparam logic [2:0] LAST_PAT = 3'(NUM_PATTERNS - 1);

    if (NUM_PATTERNS < 2 || NUM_PATTERNS > 8 || DWELL_FRAMES < 2) begin : g_bad_cfg
        $error("pattern_sequencer: NUM_PATTERNS must be 2..8 and DWELL_FRAMES >= 2");
    end

    seq_state_t        r_state;
    logic [STEP_W-1:0] r_speed;
    logic              r_btn_prev;
    logic              w_auto;
    logic              w_req;

`ifdef AUTO_CYCLE_EN
    frame_dwell_timer #(.DWELL_FRAMES(DWELL_FRAMES)) u_dwell (
        .clk    (clk),
        .rst    (rst),
        .tick   (frame_tick),
        .enable (r_state == SHOW && !pause),
        .clear  (r_state != SHOW),
        .expire (w_auto)
    );
`else
    assign w_auto = 1'b0;
`endif

    assign w_req = (btn_next && !r_btn_prev) || w_auto;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_speed <= SPEED_RESET;
        else
            r_speed <= next_speed(r_speed, speed_up, speed_down);
    end

    // Requests outside SHOW fall through the case and are dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= SHOW;
            r_btn_prev  <= 1'b0;
            next_frame  <= 1'b0;
            step_size   <= SPEED_RESET;
            pattern_sel <= 3'd0;
            dim         <= 2'd0;
            busy        <= 1'b0;
        end else begin
            r_btn_prev <= btn_next;
            next_frame <= frame_tick && !pause;
            if (frame_tick)
                step_size <= r_speed;
            case (r_state)
                SHOW: begin
                    if (w_req) begin
                        r_state <= FADE_OUT;
                        busy    <= 1'b1;
                    end
                end
                FADE_OUT: begin
                    if (frame_tick) begin
                        if (dim == DIM_MAX)
                            r_state <= SWAP;
                        else
                            dim <= dim + 2'd1;
                    end
                end
                SWAP: begin
                    pattern_sel <= (pattern_sel == LAST_PAT) ? 3'd0 : pattern_sel + 3'd1;
                    r_state     <= FADE_IN;
                end
                FADE_IN: begin
                    if (frame_tick) begin
                        dim <= dim - 2'd1;
                        if (dim == 2'd1) begin
                            r_state <= SHOW;
                            busy    <= 1'b0;
                        end
                    end
                end
                default: r_state <= SHOW;
            endcase
        end
    end

endmodule

// File: tb/tb_pattern_sequencer.sv
// tb_pattern_sequencer: vector table, corner-case sequences and randomized run against a frame-level model.
module tb_pattern_sequencer;

    localparam int NP = 4;
    localparam int DW = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       frame_tick = 1'b0, btn_next = 1'b0, speed_up = 1'b0, speed_down = 1'b0, pause = 1'b0;
    logic       next_frame, busy;
    logic [2:0] step_size, pattern_sel;
    logic [1:0] dim;

    int n_chk  = 0;
    int n_fail = 0;

    pattern_sequencer #(.NUM_PATTERNS(NP), .DWELL_FRAMES(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .frame_tick  (frame_tick),
        .btn_next    (btn_next),
        .speed_up    (speed_up),
        .speed_down  (speed_down),
        .pause       (pause),
        .next_frame  (next_frame),
        .step_size   (step_size),
        .pattern_sel (pattern_sel),
        .dim         (dim),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Model: a change is "active" and counts frame ticks 0..7; the swap consumes the cycle after tick 4.
    int m_speed, m_step, m_pat, m_ticks, m_dwell;
    bit m_nf, m_active, m_swapped, m_prev;

    task automatic m_reset();
        m_speed = 4; m_step = 4; m_pat = 0; m_ticks = 0; m_dwell = 0;
        m_nf = 0; m_active = 0; m_swapped = 0; m_prev = 0;
    endtask

    task automatic m_clock(input bit t, input bit b, input bit u, input bit d, input bit p);
        bit req;
        req = b && !m_prev;
`ifdef AUTO_CYCLE_EN
        if (!m_active && t && !p) begin
            m_dwell++;
            if (m_dwell == DW) begin
                req = 1;
                m_dwell = 0;
            end
        end
`endif
        m_nf = t && !p;
        if (t) m_step = m_speed;
        if (u && !d) m_speed = (m_speed < 7) ? m_speed + 1 : 7;
        if (d && !u) m_speed = (m_speed > 0) ? m_speed - 1 : 0;
        m_prev = b;
        if (m_active) begin
            m_dwell = 0;
            if (m_ticks == 4 && !m_swapped) begin
                m_swapped = 1;
                m_pat = (m_pat + 1) % NP;
            end else if (t) begin
                m_ticks++;
                if (m_ticks == 7) m_active = 0;
            end
        end else if (req) begin
            m_active = 1; m_ticks = 0; m_swapped = 0;
        end
    endtask

    function automatic int m_dim();
        return !m_active ? 0 : (m_ticks < 4 ? m_ticks : 7 - m_ticks);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input bit t, input bit b, input bit u, input bit d, input bit p);
        frame_tick = t; btn_next = b; speed_up = u; speed_down = d; pause = p;
        @(posedge clk);
        m_clock(t, b, u, d, p);
        #1;
    endtask

    task automatic do_reset();
        frame_tick = 0; btn_next = 0; speed_up = 0; speed_down = 0; pause = 0;
        rst = 1;
        m_reset();
        repeat (2) @(posedge clk);
        #1 rst = 0;
    endtask

    // Full change with every cycle ticking and paused: 4 fade-out, swap, 3 fade-in.
    task automatic paused_change();
        cyc(0, 1, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        for (int i = 0; i < 8; i++) begin
            cyc(1, 0, 0, 0, 1);
            chk("paused_nf", next_frame, 0);
        end
    endtask

    typedef struct {
        bit t, b, u, d, p;
        bit nf;
        int step, pat, dm;
        bit bz;
    } vec_t;

    vec_t vecs[22];

    initial begin
        vecs[0]  = '{0,0,0,0,0, 0,4,0,0,0};
        vecs[1]  = '{1,0,0,0,0, 1,4,0,0,0};
        vecs[2]  = '{0,0,0,0,0, 0,4,0,0,0};
        vecs[3]  = '{1,0,0,0,0, 1,4,0,0,0};
        vecs[4]  = '{1,0,0,0,0, 1,4,0,0,0};
        vecs[5]  = '{0,0,1,0,0, 0,4,0,0,0};
        vecs[6]  = '{0,0,1,1,0, 0,4,0,0,0};
        vecs[7]  = '{1,0,0,0,0, 1,5,0,0,0};
        vecs[8]  = '{0,0,0,1,0, 0,5,0,0,0};
        vecs[9]  = '{1,0,0,0,1, 0,4,0,0,0};
        vecs[10] = '{0,1,0,0,0, 0,4,0,0,1};
        vecs[11] = '{0,1,0,0,0, 0,4,0,0,1};
        vecs[12] = '{1,0,0,0,0, 1,4,0,1,1};
        vecs[13] = '{1,0,0,0,0, 1,4,0,2,1};
        vecs[14] = '{1,0,0,0,1, 0,4,0,3,1};
        vecs[15] = '{1,0,0,0,0, 1,4,0,3,1};
        vecs[16] = '{1,0,0,0,0, 1,4,1,3,1};
        vecs[17] = '{1,0,0,0,0, 1,4,1,2,1};
        vecs[18] = '{0,1,0,0,0, 0,4,1,2,1};
        vecs[19] = '{1,0,0,0,0, 1,4,1,1,1};
        vecs[20] = '{1,0,0,0,0, 1,4,1,0,0};
        vecs[21] = '{0,0,0,0,0, 0,4,1,0,0};

        do_reset();
        chk("rst_nf", next_frame, 0);
        chk("rst_step", step_size, 4);
        chk("rst_pat", pattern_sel, 0);
        chk("rst_dim", dim, 0);
        chk("rst_busy", busy, 0);

`ifndef AUTO_CYCLE_EN
        foreach (vecs[i]) begin
            cyc(vecs[i].t, vecs[i].b, vecs[i].u, vecs[i].d, vecs[i].p);
            chk($sformatf("vec%0d_nf", i), next_frame, vecs[i].nf);
            chk($sformatf("vec%0d_step", i), step_size, vecs[i].step);
            chk($sformatf("vec%0d_pat", i), pattern_sel, vecs[i].pat);
            chk($sformatf("vec%0d_dim", i), dim, vecs[i].dm);
            chk($sformatf("vec%0d_busy", i), busy, vecs[i].bz);
        end
`endif

        // Speed saturation, ticks paused so no dwell counting.
        do_reset();
        repeat (8) cyc(0, 0, 1, 0, 0);
        cyc(1, 0, 0, 0, 1);
        chk("speed_max", step_size, 7);
        repeat (10) cyc(0, 0, 0, 1, 0);
        cyc(1, 0, 0, 0, 1);
        chk("speed_min", step_size, 0);
        cyc(0, 0, 1, 1, 0);
        cyc(1, 0, 0, 0, 1);
        chk("speed_both", step_size, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(1, 0, 0, 0, 1);
        chk("speed_one", step_size, 1);

        // Four changes wrap pattern_sel 3 -> 0.
        do_reset();
        for (int k = 1; k <= 4; k++) begin
            paused_change();
            chk("wrap_pat", pattern_sel, k % NP);
            chk("wrap_dim", dim, 0);
            chk("wrap_busy", busy, 0);
        end

        // Asynchronous reset mid fade-out.
        paused_change();
        cyc(0, 0, 1, 0, 0);
        cyc(1, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        chk("pre_rst_dim", dim, 2);
        chk("pre_rst_step", step_size, 5);
        chk("pre_rst_pat", pattern_sel, 1);
        #2 rst = 1;
        #1;
        chk("arst_dim", dim, 0);
        chk("arst_busy", busy, 0);
        chk("arst_pat", pattern_sel, 0);
        chk("arst_step", step_size, 4);
        chk("arst_nf", next_frame, 0);
        do_reset();

`ifdef AUTO_CYCLE_EN
        repeat (3) cyc(1, 0, 0, 0, 0);
        repeat (2) cyc(1, 0, 0, 0, 1);
        chk("dwell_frozen", busy, 0);
        cyc(1, 0, 0, 0, 0);
        chk("dwell_expire", busy, 1);
        do_reset();
`endif

        for (int i = 0; i < 4000; i++) begin
            cyc($urandom_range(0, 5) == 0, (i % 40) < 20 ? $urandom_range(0, 9) == 0 : btn_next,
                $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 4) == 0);
            chk("rnd_nf", next_frame, m_nf);
            chk("rnd_step", step_size, m_step);
            chk("rnd_pat", pattern_sel, m_pat);
            chk("rnd_dim", dim, m_dim());
            chk("rnd_busy", busy, m_active);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
